// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 8-digit display scanner.
package scan_ctrl_pkg;

    localparam int unsigned NDIG  = 8;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Digit index to one-hot select; digit 0 maps to the msb.
    function automatic logic [NDIG-1:0] digit_onehot(input logic [IDX_W-1:0] d);
        digit_onehot = {{(NDIG-1){1'b0}}, 1'b1} << (IDX_W'(NDIG - 1) - d);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Load/countdown timer for dwell and gap phases; terminal count is a value of 1.
module scan_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c,
    output logic         tc_next_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tc_c = (cnt == W'(1));
    // True when the count after the coming edge will be the last cycle of the phase.
    assign tc_next_c = !clr && (load ? (load_val == W'(1)) : (cnt == W'(2)));

endmodule

// File: rtl/scan_ctrl.sv
// Display scan controller: shadow/active digit buffers, dwell/gap sequencing,
// frame-boundary commit and leading-zero blanking. All outputs registered.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1000,
    parameter int unsigned GAP_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        commit,
    input  logic        blank_lz,
    output logic [7:0]  scan,
    output logic [3:0]  seg,
    output logic        frame_done,
    output logic        commit_ack
);

    localparam int unsigned MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned TW   = ($clog2(MAXC + 1) > 2) ? $clog2(MAXC + 1) : 2;
    localparam state_t      LAST_ST = (GAP_CYC == 0) ? ST_SHOW : ST_GAP;

    state_t                        st, st_n;
    logic [IDX_W-1:0]              d, d_n;
    logic                          pending, pending_n;
    logic [NDIG-1:0][DIG_W-1:0]    shadow, shadow_n, active, active_n;
    logic                          tmr_clr, tmr_load, tc_c, tc_next_c;
    logic [TW-1:0]                 tmr_val;
    logic                          pend_eff, boundary_n, copy_n, blank_n, drive_n;
    logic [NDIG-1:0]               nz, prefix_mask, scan_n;
    logic [DIG_W-1:0]              seg_n;

    scan_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .tc_c      (tc_c),
        .tc_next_c (tc_next_c)
    );

    // Next state, digit index and timer control.
    always_comb begin
        st_n     = st;
        d_n      = d;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (st)
            ST_OFF: begin
                if (en) begin
                    st_n     = ST_SHOW;
                    d_n      = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CLK_DIV);
                end else begin
                    tmr_clr = 1'b1;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    st_n    = ST_OFF;
                    d_n     = '0;
                    tmr_clr = 1'b1;
                end else if (tc_c) begin
                    tmr_load = 1'b1;
                    if (GAP_CYC != 0) begin
                        st_n    = ST_GAP;
                        tmr_val = TW'(GAP_CYC);
                    end else begin
                        d_n     = d + IDX_W'(1);
                        tmr_val = TW'(CLK_DIV);
                    end
                end
            end
            ST_GAP: begin
                if (!en) begin
                    st_n    = ST_OFF;
                    d_n     = '0;
                    tmr_clr = 1'b1;
                end else if (tc_c) begin
                    st_n     = ST_SHOW;
                    d_n      = d + IDX_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CLK_DIV);
                end
            end
            default: begin
                st_n    = ST_OFF;
                d_n     = '0;
                tmr_clr = 1'b1;
            end
        endcase
    end

    // Buffers, commit and registered display values for the upcoming cycle.
    always_comb begin
        shadow_n = shadow;
        if (wr_en)
            shadow_n[wr_addr] = wr_data;
        pend_eff   = pending | commit;
        boundary_n = (st_n == LAST_ST) && (d_n == IDX_W'(NDIG - 1)) && tc_next_c;
        copy_n     = pend_eff && (boundary_n || (st == ST_OFF));
        pending_n  = pend_eff && !copy_n;
        active_n   = copy_n ? shadow_n : active;

        nz = '0;
        for (int k = 0; k < NDIG; k++)
            nz[k] = |active_n[k];
        prefix_mask = ({{(NDIG-2){1'b0}}, 2'b10} << d_n) - {{(NDIG-1){1'b0}}, 1'b1};
        blank_n     = blank_lz && (d_n != IDX_W'(NDIG - 1)) && ((nz & prefix_mask) == '0);
        drive_n     = (st_n == ST_SHOW) && !blank_n;
        scan_n      = drive_n ? digit_onehot(d_n) : '0;
        seg_n       = drive_n ? active_n[d_n] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_OFF;
            d          <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            active     <= '0;
            scan       <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            st         <= st_n;
            d          <= d_n;
            pending    <= pending_n;
            shadow     <= shadow_n;
            active     <= active_n;
            scan       <= scan_n;
            seg        <= seg_n;
            frame_done <= boundary_n;
            commit_ack <= copy_n;
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: two instances (dwell 4/gap 1 and dwell 1/no gap) against a frame-position model.
module tb_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, commit, blank_lz;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] scan_a, scan_b;
    logic [3:0] seg_a, seg_b;
    logic       fd_a, fd_b, ack_a, ack_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    scan_ctrl #(.CLK_DIV(4), .GAP_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .blank_lz(blank_lz), .scan(scan_a), .seg(seg_a),
        .frame_done(fd_a), .commit_ack(ack_a)
    );

    scan_ctrl #(.CLK_DIV(1), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .blank_lz(blank_lz), .scan(scan_b), .seg(seg_b),
        .frame_done(fd_b), .commit_ack(ack_b)
    );

    // Model: position within the frame, buffers as flat vectors, outputs for the current cycle.
    typedef struct packed {
        logic        on;
        logic [31:0] pos;
        logic        pend;
        logic [31:0] sh;
        logic [31:0] act;
        logic [7:0]  scan;
        logic [3:0]  seg;
        logic        fd;
        logic        ack;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(input mdl_t m, input logic i_en, input logic i_we,
                                  input logic [2:0] i_wa, input logic [3:0] i_wd,
                                  input logic i_cm, input logic i_blz, input int cd, input int gc);
        mdl_t r;
        int   per, flen, dig, p;
        logic pe, bnd, cp, lead;
        r    = m;
        per  = cd + gc;
        flen = 8 * per;
        if (i_we)
            r.sh[int'(i_wa)*4 +: 4] = i_wd;
        pe = m.pend | i_cm;
        if (!i_en) begin
            r.on = 1'b0; r.pos = 0;
        end else if (!m.on) begin
            r.on = 1'b1; r.pos = 0;
        end else begin
            r.pos = 32'((int'(m.pos) + 1) % flen);
        end
        p   = int'(r.pos);
        bnd = r.on && (p == flen - 1);
        cp  = pe && (bnd || !m.on);
        r.pend = pe && !cp;
        if (cp)
            r.act = r.sh;
        r.fd  = bnd;
        r.ack = cp;
        dig  = p / per;
        lead = 1'b1;
        for (int k = 0; k <= dig; k++)
            if (r.act[k*4 +: 4] != 4'd0)
                lead = 1'b0;
        if (r.on && (p % per) < cd && !(i_blz && dig < 7 && lead)) begin
            r.scan = 8'h80 >> dig;
            r.seg  = r.act[dig*4 +: 4];
        end else begin
            r.scan = 8'h00;
            r.seg  = 4'h0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, en, wr_en, wr_addr, wr_data, commit, blank_lz, 4, 1);
            mb <= step(mb, en, wr_en, wr_addr, wr_data, commit, blank_lz, 1, 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a.scan", 32'(scan_a), 32'(ma.scan));
        chk("a.seg",  32'(seg_a),  32'(ma.seg));
        chk("a.fd",   32'(fd_a),   32'(ma.fd));
        chk("a.ack",  32'(ack_a),  32'(ma.ack));
        chk("b.scan", 32'(scan_b), 32'(mb.scan));
        chk("b.seg",  32'(seg_b),  32'(mb.seg));
        chk("b.fd",   32'(fd_b),   32'(mb.fd));
        chk("b.ack",  32'(ack_b),  32'(mb.ack));
    end

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ma.fd && n < budget);
        chk("wait_fd", 32'(ma.fd), 32'd1);
    endtask

    task automatic wait_pos(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ma.on && int'(ma.pos) == target) && n < budget);
        chk("wait_pos", 32'(ma.pos), 32'(target));
    endtask

    task automatic write_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = w[i*4 +: 4];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    logic [7:0] blank_tbl [8];
    int         acks;
    logic [7:0] exp_s;

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; commit = 1'b0; blank_lz = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst.scan", 32'(scan_a), 32'h0);
        chk("rst.seg",  32'(seg_a),  32'h0);
        chk("rst.fd",   32'(fd_a),   32'h0);
        chk("rst.ack",  32'(ack_a),  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("off.scan", 32'(scan_a), 32'h0);

        // Enable: 80x4,00,40x4,00,...,01x4,00 with frame_done on cycle 40 only.
        en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            exp_s = (((c - 1) % 5) < 4) ? (8'h80 >> ((c - 1) / 5)) : 8'h00;
            chk("seq.scan", 32'(scan_a), 32'(exp_s));
            chk("seq.fd",   32'(fd_a),   32'(c == 40));
        end

        // Atomic commit of 1..8 mid-frame.
        write_word(32'h8765_4321);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("old.seg", 32'(seg_a), 32'h0);
        wait_fd(100);
        chk("commit.ack", 32'(ack_a), 32'h1);
        chk("commit.fd",  32'(fd_a),  32'h1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 5 < 4)
                chk("new.seg", 32'(seg_a), 32'(c / 5 + 1));
        end

        // Commit and write on the boundary edge.
        wait_pos(38, 100);
        commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'hA;
        @(negedge clk);
        commit = 1'b0; wr_en = 1'b0;
        chk("race.fd",  32'(fd_a),  32'h1);
        chk("race.ack", 32'(ack_a), 32'h1);
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acks += int'(ack_a);
            if (c == 35)
                chk("race.seg7", 32'(seg_a), 32'hA);
        end
        chk("race.acks", 32'(acks), 32'h0);

        // Leading-zero blanking with 0,0,3,0,0,0,0,0.
        blank_lz = 1'b1;
        write_word(32'h0000_0300);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_fd(100);
        blank_tbl = '{8'h00, 8'h00, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 5 == 0)
                chk("blank.scan", 32'(scan_a), 32'(blank_tbl[c / 5]));
            if (c == 10)
                chk("blank.seg2", 32'(seg_a), 32'h3);
        end

        // All zeros: only digit 7 driven.
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h0; commit = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b0;
        wait_fd(100);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 5 == 0)
                chk("zero.scan", 32'(scan_a), (c == 35) ? 32'h01 : 32'h00);
        end

        // Abort in the middle of digit 5.
        blank_lz = 1'b0;
        wait_pos(27, 100);
        en = 1'b0;
        @(negedge clk);
        chk("abort.scan", 32'(scan_a), 32'h0);
        chk("abort.fd",   32'(fd_a),   32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("off.fd", 32'(fd_a), 32'h0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("restart.scan", 32'(scan_a), 32'h80);
        chk("restart.scan_b", 32'(scan_b), 32'h80);

        // No-gap instance rotates every cycle with a frame pulse every 8.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("nogap.scan", 32'(scan_b), 32'(8'h80 >> (i % 8)));
            chk("nogap.fd",   32'(fd_b),   32'(i % 8 == 7));
        end

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 99) < 97);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            commit  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0)
                blank_lz = ~blank_lz;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
